// File: rtl/alu_exec_unit.sv
// Execute stage behind the 16x16 register file: one-cycle ALU ops plus a 16-step
// shift-add multiply, finishing with a one-cycle write-back strobe.
//   state  | meaning
//   S_IDLE | waiting for Start; Busy low
//   S_EXEC | single-cycle ALU op completes on the next edge
//   S_MUL  | shift-add multiply, one partial product per edge
module alu_exec_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [ADDR_W-1:0] Dst_addr,
    input  logic [WIDTH-1:0]  Src,
    input  logic [WIDTH-1:0]  Dest,
    output logic              Busy,
    output logic              Done,
    output logic              WR,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [WIDTH-1:0]  Result,
    output logic              Z,
    output logic              N,
    output logic              C
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WIDTH-1:0]    a_q, b_q;
    logic [2*WIDTH-1:0]  acc_q, mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q, done_q, wr_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [WIDTH-1:0]    result_q;
    logic                z_q, n_q, c_q;

    logic [CNT_W-1:0]    shamt;
    logic [WIDTH:0]      sum, diff, shl, shr;
    logic [WIDTH-1:0]    alu_res_d, fin_res_d;
    logic                alu_c_d, fin_c_d;
    logic [2*WIDTH-1:0]  acc_d;

    always_comb begin
        shamt     = b_q[CNT_W-1:0];
        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = {1'b0, a_q} - {1'b0, b_q};
        shl       = {1'b0, a_q} << shamt;
        // Extra low bit catches the last bit shifted out to the right.
        shr       = {a_q, 1'b0} >> shamt;
        alu_res_d = '0;
        alu_c_d   = 1'b0;
        case (op_q)
            3'b000:  begin alu_res_d = sum[WIDTH-1:0];  alu_c_d = sum[WIDTH];  end
            3'b001:  begin alu_res_d = diff[WIDTH-1:0]; alu_c_d = diff[WIDTH]; end
            3'b010:  alu_res_d = a_q & b_q;
            3'b011:  alu_res_d = a_q | b_q;
            3'b100:  alu_res_d = a_q ^ b_q;
            3'b101:  begin alu_res_d = shl[WIDTH-1:0];  alu_c_d = shl[WIDTH];  end
            3'b110:  begin alu_res_d = shr[WIDTH:1];    alu_c_d = shr[0];      end
            default: ;
        endcase
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
        fin_res_d = (state_q == S_MUL) ? acc_d[WIDTH-1:0] : alu_res_d;
        fin_c_d   = (state_q == S_MUL) ? (|acc_d[2*WIDTH-1:WIDTH]) : alu_c_d;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            result_q  <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wr_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        op_q     <= Op;
                        addr_q   <= Dst_addr;
                        a_q      <= Dest;
                        b_q      <= Src;
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, Dest};
                        mplier_q <= Src;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= (Op == 3'b111) ? S_MUL : S_EXEC;
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        wr_q      <= 1'b1;
                        wr_addr_q <= addr_q;
                        result_q  <= fin_res_d;
                        z_q       <= (fin_res_d == '0);
                        n_q       <= fin_res_d[WIDTH-1];
                        c_q       <= fin_c_d;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    wr_q      <= 1'b1;
                    wr_addr_q <= addr_q;
                    result_q  <= fin_res_d;
                    z_q       <= (fin_res_d == '0);
                    n_q       <= fin_res_d[WIDTH-1];
                    c_q       <= fin_c_d;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign WR      = wr_q;
    assign Wr_addr = wr_addr_q;
    assign Result  = result_q;
    assign Z       = z_q;
    assign N       = n_q;
    assign C       = c_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed literal cases plus randomized traffic checked
// every cycle against an arithmetic model with per-op latency countdown.
module tb_alu_exec_unit;
    logic        CLK = 1'b0;
    logic        RSTn, Start;
    logic [2:0]  Op;
    logic [3:0]  Dst_addr, Wr_addr;
    logic [15:0] Src, Dest, Result;
    logic        Busy, Done, WR, Z, N, C;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    alu_exec_unit #(.WIDTH(16), .ADDR_W(4)) dut (
        .CLK(CLK), .RSTn(RSTn), .Start(Start), .Op(Op), .Dst_addr(Dst_addr),
        .Src(Src), .Dest(Dest), .Busy(Busy), .Done(Done), .WR(WR),
        .Wr_addr(Wr_addr), .Result(Result), .Z(Z), .N(N), .C(C)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Returns {carry, result} from plain integer arithmetic.
    function automatic logic [16:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int unsigned ua, ub, n, r, c;
        ua = a; ub = b; n = ub % 16; c = 0; r = 0;
        case (op)
            3'd0: begin r = ua + ub; c = (r >> 16) & 1; end
            3'd1: begin r = ua + 65536 - ub; c = (ua < ub) ? 1 : 0; end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua << n; c = (n == 0) ? 0 : (ua >> (16 - n)) & 1; end
            3'd6: begin r = ua >> n; c = (n == 0) ? 0 : (ua >> (n - 1)) & 1; end
            default: begin r = ua * ub; c = ((r >> 16) != 0) ? 1 : 0; end
        endcase
        return {c[0], r[15:0]};
    endfunction

    logic        m_busy, m_done, m_wr, m_z, m_n, m_c;
    logic [3:0]  m_addr, p_addr;
    logic [15:0] m_res, p_res;
    logic        p_c;
    int          m_cnt;

    always @(posedge CLK) begin
        logic [16:0] mr;
        if (!RSTn) begin
            m_busy = 0; m_done = 0; m_wr = 0; m_z = 0; m_n = 0; m_c = 0;
            m_addr = 0; m_res = 0; m_cnt = 0;
        end else begin
            m_wr = 0; m_done = 0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0; m_wr = 1; m_done = 1;
                    m_res = p_res; m_c = p_c; m_z = (p_res == 0); m_n = p_res[15];
                    m_addr = p_addr;
                end
            end else if (Start) begin
                mr = model(Op, Dest, Src);
                p_res = mr[15:0]; p_c = mr[16]; p_addr = Dst_addr;
                m_busy = 1;
                m_cnt = (Op == 3'd7) ? 16 : 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cyc busy", Busy, m_busy);
            chk("cyc done", Done, m_done);
            chk("cyc wr", WR, m_wr);
            chk("cyc result", Result, m_res);
            chk("cyc z", Z, m_z);
            chk("cyc n", N, m_n);
            chk("cyc c", C, m_c);
            if (m_wr) chk("cyc wr_addr", Wr_addr, m_addr);
        end
    end

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " busy"}, Busy, 0);
        chk({nm, " done"}, Done, 0);
        chk({nm, " wr"}, WR, 0);
        chk({nm, " result"}, Result, 0);
        chk({nm, " zns"}, {Z, N, C}, 0);
        chk({nm, " wr_addr"}, Wr_addr, 0);
    endtask

    // Called at a falling edge; returns at the falling edge where WR is seen.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] dst, input logic [15:0] er,
                          input logic ez, input logic en, input logic ec);
        int cyc;
        cyc = 0;
        Start = 1; Op = op; Dest = a; Src = b; Dst_addr = dst;
        do begin
            @(negedge CLK);
            Start = 0; Dest = 16'($urandom); Src = 16'($urandom); Dst_addr = 4'($urandom);
            cyc++;
        end while (!WR && cyc < 40);
        chk({nm, " latency"}, cyc, (op == 3'd7) ? 17 : 2);
        chk({nm, " result"}, Result, er);
        chk({nm, " z"}, Z, ez);
        chk({nm, " n"}, N, en);
        chk({nm, " c"}, C, ec);
        chk({nm, " wr_addr"}, Wr_addr, dst);
        chk({nm, " done"}, Done, 1);
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'($urandom_range(0, 17));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int wrs;
        RSTn = 0; Start = 0; Op = 0; Dst_addr = 0; Src = 0; Dest = 0;
        chk("model add", model(3'd0, 16'hFFFF, 16'h0001), 17'h10000);
        chk("model sub", model(3'd1, 16'h0001, 16'h0002), 17'h1FFFF);
        chk("model shl", model(3'd5, 16'h8001, 16'h0001), 17'h10002);
        chk("model mul", model(3'd7, 16'h0012, 16'h0034), 17'h003A8);
        @(negedge CLK);
        @(negedge CLK);
        chk_reset_outputs("reset");
        chk_en = 1;
        RSTn = 1;
        @(negedge CLK);

        run_op("add1", 3'd0, 16'h1234, 16'h5678, 4'd1, 16'h68AC, 0, 0, 0);
        run_op("add2", 3'd0, 16'hFFFF, 16'h0001, 4'd2, 16'h0000, 1, 0, 1);
        run_op("sub",  3'd1, 16'h0001, 16'h0002, 4'd3, 16'hFFFF, 0, 1, 1);
        run_op("shl",  3'd5, 16'h8001, 16'h0001, 4'd4, 16'h0002, 0, 0, 1);
        run_op("shr0", 3'd6, 16'h00F0, 16'h0000, 4'd5, 16'h00F0, 0, 0, 0);
        run_op("shr3", 3'd6, 16'h00F4, 16'h0003, 4'd6, 16'h001E, 0, 0, 1);
        run_op("xor",  3'd4, 16'hA5A5, 16'hFFFF, 4'd8, 16'h5A5A, 0, 0, 0);
        run_op("mul1", 3'd7, 16'h0012, 16'h0034, 4'd7, 16'h03A8, 0, 0, 0);
        run_op("mul2", 3'd7, 16'h0100, 16'h0100, 4'd9, 16'h0000, 1, 0, 1);

        // Start during MUL is ignored; Start on the WR cycle is accepted.
        @(negedge CLK);
        Start = 1; Op = 3'd7; Dest = 16'h0012; Src = 16'h0034; Dst_addr = 4'd7;
        wrs = 0;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge CLK);
            Start = 0;
            if (cyc == 5) begin
                Start = 1; Op = 3'd0; Dest = 16'hFFFF; Src = 16'h0001; Dst_addr = 4'd3;
            end
            if (WR) wrs++;
        end
        chk("busy start wr count", wrs, 1);
        chk("busy start result", Result, 16'h03A8);
        chk("busy start wr_addr", Wr_addr, 4'd7);
        run_op("wr-cycle add", 3'd0, 16'h0010, 16'h0020, 4'd2, 16'h0030, 0, 0, 0);

        // Reset in the middle of a multiply.
        @(negedge CLK);
        Start = 1; Op = 3'd7; Dest = 16'h1234; Src = 16'h5678; Dst_addr = 4'd9;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge CLK);
            Start = 0;
        end
        RSTn = 0;
        @(negedge CLK);
        chk_reset_outputs("midreset");
        RSTn = 1;
        wrs = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge CLK);
            if (WR) wrs++;
        end
        chk("midreset no wr", wrs, 0);
        run_op("post reset add", 3'd0, 16'h0003, 16'h0004, 4'd1, 16'h0007, 0, 0, 0);

        // Random traffic, checked each cycle by the model compare process.
        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            RSTn = ($urandom_range(0, 399) != 0);
            Start = ($urandom_range(0, 2) != 0);
            Op = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            Dest = rnd16();
            Src = rnd16();
            Dst_addr = 4'($urandom);
        end
        @(negedge CLK);
        Start = 0; RSTn = 1;
        for (int i = 0; i < 20; i++) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
